store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Sits between the MEM-stage store formatter and the data memory port; consumes the zero-extended partial-word store data plus StoreSrcM.
- Aligns the data to byte lanes, generates byte strobes, and queues stores in a small FIFO.
- Drains the FIFO to data memory over a valid/ready handshake.
- Stalls the pipeline when full, on a load that hits a pending store word, or on a fence until empty.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 supported, elaboration assertion otherwise
ADDR_WIDTH, 32, byte address width
DEPTH, 4, FIFO entries; power of two, >=2

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
MemWriteM  in  1  store instruction in MEM
MemReadM  in  1  load instruction in MEM
FenceM  in  1  fence in MEM; hold until buffer empty
StoreSrcM  in  2  00 SW, 01 SB, 10 SH, 11 illegal
ALUResultM  in  ADDR_WIDTH  byte address
WritePartDataM  in  DATA_WIDTH  store data, right-justified, upper bits zero
StallM  out  1  freeze MEM and earlier stages
MisalignedM  out  1  one-cycle pulse: store dropped, misaligned or illegal StoreSrcM
BufEmpty  out  1  no pending stores
DMemValid  out  1  head entry valid toward memory
DMemAddr  out  ADDR_WIDTH  word-aligned address, bits [1:0]=0
DMemWData  out  DATA_WIDTH  lane-aligned write data
DMemStrb  out  DATA_WIDTH/8  byte write enables
DMemReady  in  1  memory accepts head this cycle

Behaviour:
- Reset (async, reset_n low): count=0, pointers=0, all entries invalid.
  - Outputs: DMemValid=0, BufEmpty=1, StallM=0, MisalignedM=0, DMem* data/addr/strb=0.
  - Pending stores are discarded. Reset mid-handshake is legal; memory must tolerate the valid drop.
- Lane alignment, off = ALUResultM[1:0]:
  - SB: strb = 0001<<off; data = WritePartDataM << (8*off).
  - SH: off[0] must be 0; strb = 0011<<off; data << (8*off).
  - SW: off must be 00; strb = 1111; data unshifted.
- Drop rules: misaligned store or StoreSrcM=11 with MemWriteM=1 is not enqueued. MisalignedM=1 next cycle for exactly one cycle; no stall.
- Enqueue: MemWriteM & legal & !full & !StallM-from-load/fence. Entry captured at the rising edge. Latency from enqueue edge to DMemValid is 1 cycle.
- Full: MemWriteM & count==DEPTH -> StallM=1 combinationally. No same-cycle pop bypass; accepted on a later cycle.
- Drain:
  - DMemValid = (count!=0); head fields driven from registers.
  - Entry pops on DMemValid & DMemReady.
  - Head is stable while DMemValid & !DMemReady.
  - Back-to-back pops allowed, one per cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Load hazard:
  - MemReadM & any valid entry with addr[ADDR_WIDTH-1:2] == ALUResultM[ADDR_WIDTH-1:2] -> StallM=1.
  - Conservative: stall even if the matching entry pops this cycle.
  - Non-matching loads never stall.
- Fence: FenceM & count!=0 -> StallM=1; released the cycle after count reaches 0 (BufEmpty=1).
- Pointer wrap: modulo DEPTH, with an extra count register for the full/empty distinction.
- StallM is combinational from inputs and registered state. It never depends on DMemReady, avoiding a memory-to-pipeline comb path.

Decomposition:
- Package store_buf_pkg holds:
  - StoreSrc constants SRC_SW/SRC_SB/SRC_SH;
  - typedef struct store_entry_t {addr, data, strb};
  - function lane_align(src, off, data) returning data/strb/legal.
- One sub-module, store_fifo: generic DEPTH-entry FIFO of store_entry_t with push/pop/count/full/empty and a parallel word-address compare output (match vector).

Test Plan:
- SB addr 0x103, data 0xAB -> entry strb 1000, DMemWData 0xAB000000, DMemAddr 0x100; DMemValid next cycle, pops on DMemReady.
- SH addr 0x202, data 0x1234; then SH addr 0x201 -> first gives strb 1100, data 0x12340000; second dropped, MisalignedM 1-cycle pulse, count unchanged.
- DMemReady=0, five SW back to back -> first four enqueued, fifth holds StallM=1. Raise DMemReady -> one pop, fifth enqueues next cycle, order preserved at memory.
- Pending SW 0x300 with DMemReady=0; LW 0x302 -> StallM=1 until the entry pops. LW 0x400 -> StallM=0.
- Three stores queued, FenceM=1 -> StallM=1 until BufEmpty=1. Push and pop in the same cycle leaves count constant.
- Assert reset_n low while DMemValid=1 with two entries -> DMemValid, StallM=0 and BufEmpty=1 immediately; after release no stale entries are emitted.

Source files
------------

// File: rtl/store_buf_pkg.sv
// Shared types and byte-lane alignment for the store write buffer.
package store_buf_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] SRC_SW = 2'b00;
    localparam logic [1:0] SRC_SB = 2'b01;
    localparam logic [1:0] SRC_SH = 2'b10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } store_entry_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              legal;
    } lane_t;

    function automatic lane_t lane_align(
        input logic [1:0]        src,
        input logic [1:0]        off,
        input logic [DATA_W-1:0] data
    );
        lane_t r;
        r = '0;
        case (src)
            SRC_SB: begin
                r.legal = 1'b1;
                r.strb  = 4'b0001 << off;
                r.data  = data << {off, 3'b000};
            end
            SRC_SH: begin
                r.legal = ~off[0];
                r.strb  = 4'b0011 << off;
                r.data  = data << {off, 3'b000};
            end
            SRC_SW: begin
                r.legal = (off == 2'b00);
                r.strb  = 4'b1111;
                r.data  = data;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/store_write_buffer_fifo.sv
// DEPTH-entry store FIFO with per-entry valid bits and a parallel
// word-address compare used for load hazard detection.
module store_fifo
    import store_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic               pop,
    input  store_entry_t       wr_entry,
    input  logic [ADDR_W-3:0]  cmp_word,
    output store_entry_t       head,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic [DEPTH-1:0]   match
);

    store_entry_t     mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // push needs !full and pop needs !empty, so pointers never collide
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++)
            match[i] = vld[i] && (mem[i].addr[ADDR_W-1:2] == cmp_word);
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/store_write_buffer.sv
// MEM-stage store write buffer: lane alignment, queueing, drain to
// data memory, and pipeline stall generation.
module store_write_buffer
    import store_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    MemWriteM,
    input  logic                    MemReadM,
    input  logic                    FenceM,
    input  logic [1:0]              StoreSrcM,
    input  logic [ADDR_WIDTH-1:0]   ALUResultM,
    input  logic [DATA_WIDTH-1:0]   WritePartDataM,
    output logic                    StallM,
    output logic                    MisalignedM,
    output logic                    BufEmpty,
    output logic                    DMemValid,
    output logic [ADDR_WIDTH-1:0]   DMemAddr,
    output logic [DATA_WIDTH-1:0]   DMemWData,
    output logic [DATA_WIDTH/8-1:0] DMemStrb,
    input  logic                    DMemReady
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (DATA_WIDTH != DATA_W || ADDR_WIDTH != ADDR_W) begin : g_bad_width
        $error("store_write_buffer: only 32-bit data/address supported");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("store_write_buffer: DEPTH must be a power of two >= 2");
    end

    lane_t            lane;
    store_entry_t     wr_entry;
    store_entry_t     head;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic [DEPTH-1:0] match;
    logic             push;
    logic             pop;
    logic             mis_q;

    assign lane = lane_align(StoreSrcM, ALUResultM[1:0], WritePartDataM);

    assign wr_entry.addr = {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
    assign wr_entry.data = lane.data;
    assign wr_entry.strb = lane.strb;

    // Independent of DMemReady: no memory-to-pipeline combinational path
    assign StallM = (MemWriteM && lane.legal && full)
                  || (MemReadM && (|match))
                  || (FenceM && !empty);

    assign push = MemWriteM && lane.legal && !StallM;
    assign pop  = DMemValid && DMemReady;

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .cmp_word (ALUResultM[ADDR_WIDTH-1:2]),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .match    (match)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mis_q <= 1'b0;
        else          mis_q <= MemWriteM && !lane.legal;
    end

    assign MisalignedM = mis_q;
    assign BufEmpty    = empty;
    assign DMemValid   = (count != '0);
    assign DMemAddr    = DMemValid ? head.addr : '0;
    assign DMemWData   = DMemValid ? head.data : '0;
    assign DMemStrb    = DMemValid ? head.strb : '0;

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: directed cases then random traffic.
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        MemReadM = 1'b0;
    logic        FenceM = 1'b0;
    logic [1:0]  StoreSrcM = 2'b00;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WritePartDataM = '0;
    logic        StallM;
    logic        MisalignedM;
    logic        BufEmpty;
    logic        DMemValid;
    logic [31:0] DMemAddr;
    logic [31:0] DMemWData;
    logic [3:0]  DMemStrb;
    logic        DMemReady = 1'b0;

    store_write_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .MemWriteM      (MemWriteM),
        .MemReadM       (MemReadM),
        .FenceM         (FenceM),
        .StoreSrcM      (StoreSrcM),
        .ALUResultM     (ALUResultM),
        .WritePartDataM (WritePartDataM),
        .StallM         (StallM),
        .MisalignedM    (MisalignedM),
        .BufEmpty       (BufEmpty),
        .DMemValid      (DMemValid),
        .DMemAddr       (DMemAddr),
        .DMemWData      (DMemWData),
        .DMemStrb       (DMemStrb),
        .DMemReady      (DMemReady)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    ent_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mis_exp = 0;
    bit   last_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One pipeline cycle: drive, check combinational/registered outputs, update model
    task automatic cycle(input bit w, input bit r, input bit f, input logic [1:0] src,
                         input logic [31:0] a, input logic [31:0] d, input bit rdy);
        int          off;
        bit          legal;
        bit          hz;
        bit          st;
        logic [3:0]  s;
        logic [31:0] wd;
        ent_t        e;
        @(negedge clk);
        MemWriteM = w; MemReadM = r; FenceM = f; StoreSrcM = src;
        ALUResultM = a; WritePartDataM = d; DMemReady = rdy;
        off = int'(a % 4);
        legal = 0; s = 4'd0; wd = 32'd0;
        if (src == 2'd1) begin
            legal = 1; s = 4'(1 * (2 ** off)); wd = d * (32'd1 << (8 * off));
        end else if (src == 2'd2) begin
            legal = (off % 2 == 0); s = 4'(3 * (2 ** off)); wd = d * (32'd1 << (8 * off));
        end else if (src == 2'd0) begin
            legal = (off == 0); s = 4'hf; wd = d;
        end
        hz = 0;
        foreach (exp_q[i]) if (exp_q[i].addr / 4 == a / 4) hz = 1;
        st = (w && legal && exp_q.size() == DEPTH) || (r && hz) || (f && exp_q.size() != 0);
        #1;
        chk("stall", {31'd0, StallM}, {31'd0, st});
        chk("buf_empty", {31'd0, BufEmpty}, {31'd0, exp_q.size() == 0});
        chk("dmem_valid", {31'd0, DMemValid}, {31'd0, exp_q.size() != 0});
        chk("misaligned", {31'd0, MisalignedM}, {31'd0, mis_exp});
        mis_exp = w && !legal;
        if (w && legal && !st) begin
            e.addr = a - 32'(off); e.data = wd; e.strb = s;
            exp_q.push_back(e);
        end
        last_stall = st;
    endtask

    task automatic idle(input bit rdy);
        cycle(0, 0, 0, 2'd0, 32'd0, 32'd0, rdy);
    endtask

    // Monitor: score every accepted memory write against the expected queue
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #3;
            if (reset_n && DMemValid && DMemReady) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_write: addr %h with empty scoreboard", DMemAddr);
                end else begin
                    e = exp_q.pop_front();
                    chk("dmem_addr", DMemAddr, e.addr);
                    chk("dmem_wdata", DMemWData, e.data);
                    chk("dmem_strb", {28'd0, DMemStrb}, {28'd0, e.strb});
                end
            end
        end
    end

    initial begin
        bit          w, r, f, rdy;
        logic [1:0]  src;
        logic [31:0] a, d;
        int          p;
        #3;
        chk("rst_valid", {31'd0, DMemValid}, 32'd0);
        chk("rst_empty", {31'd0, BufEmpty}, 32'd1);
        chk("rst_stall", {31'd0, StallM}, 32'd0);
        chk("rst_mis", {31'd0, MisalignedM}, 32'd0);
        chk("rst_addr", DMemAddr, 32'd0);
        chk("rst_strb", {28'd0, DMemStrb}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        cycle(1, 0, 0, 2'd1, 32'h103, 32'hAB, 0);
        idle(0);
        chk("sb_wdata", DMemWData, 32'hAB000000);
        chk("sb_strb", {28'd0, DMemStrb}, 32'h8);
        idle(1);
        cycle(1, 0, 0, 2'd2, 32'h202, 32'h1234, 0);
        cycle(1, 0, 0, 2'd2, 32'h201, 32'h5678, 0);
        idle(0);
        idle(1);
        repeat (3) idle(1);

        for (int i = 0; i < 5; i++)
            cycle(1, 0, 0, 2'd0, 32'h500 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 0);
        cycle(1, 0, 0, 2'd0, 32'h510, 32'hC0DE0004, 1);
        cycle(1, 0, 0, 2'd0, 32'h510, 32'hC0DE0004, 1);
        repeat (6) idle(1);

        cycle(1, 0, 0, 2'd0, 32'h300, 32'h11223344, 0);
        cycle(0, 1, 0, 2'd0, 32'h302, 32'd0, 0);
        cycle(0, 1, 0, 2'd0, 32'h400, 32'd0, 0);
        cycle(0, 1, 0, 2'd0, 32'h302, 32'd0, 1);
        cycle(0, 1, 0, 2'd0, 32'h302, 32'd0, 1);

        for (int i = 0; i < 3; i++)
            cycle(1, 0, 0, 2'd1, 32'h600 + 32'(i), 32'(i + 1), 0);
        cycle(1, 0, 0, 2'd1, 32'h603, 32'h4, 1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 2'd0, 32'd0, 32'd0, 1);

        cycle(1, 0, 0, 2'd0, 32'h700, 32'h1, 0);
        cycle(1, 0, 0, 2'd0, 32'h704, 32'h2, 0);
        @(negedge clk);
        MemWriteM = 0; MemReadM = 0; FenceM = 1; DMemReady = 1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, DMemValid}, 32'd0);
        chk("rst_mid_stall", {31'd0, StallM}, 32'd0);
        chk("rst_mid_empty", {31'd0, BufEmpty}, 32'd1);
        exp_q.delete();
        mis_exp = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) idle(1);

        w = 0; r = 0; f = 0; src = 0; a = 0; d = 0;
        for (int n = 0; n < 400; n++) begin
            rdy = ($urandom % 3) != 0;
            if (!last_stall) begin
                p = int'($urandom % 10);
                w = (p < 5); r = (p == 5 || p == 6); f = (p == 7);
                src = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
                a = 32'h100 + 32'(4 * ($urandom % 4)) + 32'($urandom % 4);
                d = $urandom;
                if (src == 2'd1) d = d & 32'hFF;
                if (src == 2'd2) d = d & 32'hFFFF;
            end
            cycle(w, r, f, src, a, d, rdy);
        end
        for (int n = 0; n < 10; n++) idle(1);
        chk("final_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
